// File: rtl/write_buffer.sv
// Byte-to-word packer with a small word FIFO feeding the memory controller through a
// WRITE_CMD/WRITE_ACK handshake; ROW_WRITE counts acknowledged words.
module write_buffer #(
    parameter int         DEPTH    = 4,
    parameter int         ROWS     = 8192,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        CLK_48MHZ,
    input  logic        RESET,
    input  logic        BYTE_VALID,
    input  logic [7:0]  BYTE_IN,
    input  logic        FLUSH,
    input  logic        WRITE_ACK,
    output logic        WRITE_CMD,
    output logic [15:0] DATA_WRITE,
    output logic [12:0] ROW_WRITE,
    output logic        FULL,
    output logic        EMPTY,
    output logic        OVERFLOW
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW       = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [12:0] ROW_LAST = 13'(ROWS - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state_q, state_d;

    logic          pending_q, pending_d;
    logic [7:0]    low_q, low_d;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          cmd_q, cmd_d;
    logic [15:0]   data_q, data_d;
    logic [12:0]   row_q, row_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;

    logic          push_req;
    logic          push;
    logic          pop;
    logic          can_push;
    logic [15:0]   push_word;

    // Packer: decides whether this cycle produces a word and what the pending half word becomes.
    always_comb begin
        pending_d = pending_q;
        low_d     = low_q;
        push_req  = 1'b0;
        push_word = 16'h0000;

        pop      = (state_q == BUSY) && WRITE_ACK;
        can_push = (count_q != CNT_FULL) || pop;

        if (BYTE_VALID) begin
            if (pending_q) begin
                push_req  = 1'b1;
                push_word = {BYTE_IN, low_q};
            end else if (FLUSH) begin
                push_req  = 1'b1;
                push_word = {PAD_BYTE, BYTE_IN};
            end
        end else if (FLUSH && pending_q) begin
            push_req  = 1'b1;
            push_word = {PAD_BYTE, low_q};
        end

        push = push_req && can_push;

        // A lone first byte is always captured, even if its padded word cannot enter the FIFO.
        if (BYTE_VALID && !pending_q) begin
            low_d     = BYTE_IN;
            pending_d = !push;
        end else if (push) begin
            pending_d = 1'b0;
        end

        ovf_d = ovf_q || (push_req && !can_push);
    end

    // FIFO bookkeeping and registered status flags.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0) && !pending_d;
    end

    // Write handshake FSM; issues the FIFO head and pops it only once acknowledged.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        row_d   = row_q;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    data_d  = mem_q[rd_ptr_q];
                    cmd_d   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (WRITE_ACK) begin
                    cmd_d   = 1'b0;
                    state_d = IDLE;
                    row_d   = (row_q == ROW_LAST) ? 13'd0 : row_q + 13'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cmd_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            low_q     <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cmd_q     <= 1'b0;
            data_q    <= 16'h0000;
            row_q     <= 13'd0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            low_q     <= low_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            row_q     <= row_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is only read at indices the pointers have written, so it needs no reset.
    always_ff @(posedge CLK_48MHZ) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign WRITE_CMD  = cmd_q;
    assign DATA_WRITE = data_q;
    assign ROW_WRITE  = row_q;
    assign FULL       = full_q;
    assign EMPTY      = empty_q;
    assign OVERFLOW   = ovf_q;

endmodule
